// File: rtl/ahb_write_master.sv
// AHB-Lite write-side controller: takes pixel pairs over valid/ready and issues
// one SINGLE halfword NONSEQ write per pair at word-stride addresses.
module ahb_write_master #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_pairs,
   input  logic              pix_valid,
   input  logic [7:0]        pix_a,
   input  logic [7:0]        pix_b,
   output logic              pix_ready,
   input  logic              HREADY,
   input  logic              HRESP,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic              shift_enable,
   output logic [7:0]        data_out_1,
   output logic [7:0]        data_out_2,
   output logic              busy,
   output logic              frame_done,
   output logic              error
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_remaining;
   logic [1:0]        r_htrans;
   logic              r_hwrite;
   logic              r_shift_en;
   logic [7:0]        r_data_1;
   logic [7:0]        r_data_2;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_error;

   logic [CNT_W-1:0]  w_rem_dec;

   assign w_rem_dec = r_remaining - CNT_W'(1);

   // Frame sequencer; bus-facing outputs are registered alongside the state.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_remaining  <= '0;
         r_htrans     <= HTRANS_IDLE;
         r_hwrite     <= 1'b0;
         r_shift_en   <= 1'b0;
         r_data_1     <= 8'h00;
         r_data_2     <= 8'h00;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_addr      <= base_addr;
                  r_remaining <= num_pairs;
                  r_error     <= 1'b0;
                  r_busy      <= 1'b1;
                  if (num_pairs == '0) begin
                     r_state      <= ST_DONE;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (pix_valid) begin
                  r_data_1   <= pix_a;
                  r_data_2   <= pix_b;
                  r_htrans   <= HTRANS_NONSEQ;
                  r_hwrite   <= 1'b1;
                  r_shift_en <= 1'b1;
                  r_state    <= ST_ADDR;
               end
            end
            // A stalled address phase simply holds every output.
            ST_ADDR: begin
               if (HREADY) begin
                  r_htrans   <= HTRANS_IDLE;
                  r_hwrite   <= 1'b0;
                  r_shift_en <= 1'b0;
                  r_state    <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (HREADY) begin
                  if (HRESP) begin
                     r_error <= 1'b1;
                  end
                  r_addr      <= r_addr + ADDR_W'(4);
                  r_remaining <= w_rem_dec;
                  if (w_rem_dec == '0) begin
                     r_state      <= ST_DONE;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_htrans   <= HTRANS_IDLE;
               r_hwrite   <= 1'b0;
               r_shift_en <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign pix_ready    = (r_state == ST_WAIT);
   assign HADDR        = r_addr;
   assign HTRANS       = r_htrans;
   assign HWRITE       = r_hwrite;
   assign HSIZE        = 3'b001;
   assign HBURST       = 3'b000;
   assign shift_enable = r_shift_en;
   assign data_out_1   = r_data_1;
   assign data_out_2   = r_data_2;
   assign busy         = r_busy;
   assign frame_done   = r_frame_done;
   assign error        = r_error;

endmodule

// File: tb/tb_ahb_write_master.sv
// Directed bench for ahb_write_master: frames, wait states, errors, reset.
module tb_ahb_write_master;

   logic        HCLK;
   logic        HRESETn;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] num_pairs;
   logic        pix_valid;
   logic [7:0]  pix_a;
   logic [7:0]  pix_b;
   logic        pix_ready;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic        shift_enable;
   logic [7:0]  data_out_1;
   logic [7:0]  data_out_2;
   logic        busy;
   logic        frame_done;
   logic        error;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int s_cyc    = 0;
   int n_xfer   = 0;
   int xfer_base;

   ahb_write_master #(.ADDR_W(32), .CNT_W(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
      .num_pairs(num_pairs), .pix_valid(pix_valid), .pix_a(pix_a), .pix_b(pix_b),
      .pix_ready(pix_ready), .HREADY(HREADY), .HRESP(HRESP), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .shift_enable(shift_enable), .data_out_1(data_out_1), .data_out_2(data_out_2),
      .busy(busy), .frame_done(frame_done), .error(error)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) begin
      cyc <= cyc + 1;
      if (HRESETn && HTRANS == 2'b10 && HREADY) n_xfer <= n_xfer + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic begin_frame(input logic [31:0] base, input logic [15:0] num);
      start     = 1'b1;
      base_addr = base;
      num_pairs = num;
      s_cyc     = cyc;
      xfer_base = n_xfer;
      step();
      start     = 1'b0;
   endtask

   // Called in a WAIT cycle; runs one zero-wait pair and returns in the following cycle.
   task automatic do_pair(input logic [31:0] addr, input logic [7:0] a, input logic [7:0] b,
                          input logic resp);
      chk("wait_pix_ready", 32'(pix_ready), 32'd1);
      chk("wait_htrans", 32'(HTRANS), 32'd0);
      pix_valid = 1'b1;
      pix_a     = a;
      pix_b     = b;
      step();
      pix_valid = 1'b0;
      chk("addr_htrans", 32'(HTRANS), 32'h2);
      chk("addr_haddr", HADDR, addr);
      chk("addr_hwrite", 32'(HWRITE), 32'd1);
      chk("addr_shift_en", 32'(shift_enable), 32'd1);
      chk("addr_pix_ready", 32'(pix_ready), 32'd0);
      step();
      chk("data_htrans", 32'(HTRANS), 32'h0);
      chk("data_hwrite", 32'(HWRITE), 32'd0);
      chk("data_shift_en", 32'(shift_enable), 32'd0);
      chk("data_hwdata", 32'({data_out_1, data_out_2}), 32'({a, b}));
      HRESP = resp;
      step();
      HRESP = 1'b0;
   endtask

   // Bounded wait for frame_done, then latency and single-cycle pulse checks.
   task automatic wait_done(input int exp_lat, input int exp_xfer);
      for (int i = 0; i < 30; i++) begin
         if (frame_done) break;
         step();
      end
      chk("frame_done_seen", 32'(frame_done), 32'd1);
      chk("frame_latency", 32'(cyc - s_cyc), 32'(exp_lat));
      chk("done_busy", 32'(busy), 32'd1);
      chk("frame_xfers", 32'(n_xfer - xfer_base), 32'(exp_xfer));
      step();
      chk("done_pulse_end", 32'(frame_done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      HRESETn   = 1'b0;
      start     = 1'b0;
      base_addr = 32'h0;
      num_pairs = 16'h0;
      pix_valid = 1'b0;
      pix_a     = 8'h00;
      pix_b     = 8'h00;
      HREADY    = 1'b1;
      HRESP     = 1'b0;
      step();
      step();

      // Reset values
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_htrans", 32'(HTRANS), 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'd0);
      chk("rst_hsize", 32'(HSIZE), 32'h1);
      chk("rst_hburst", 32'(HBURST), 32'h0);
      chk("rst_shift_en", 32'(shift_enable), 32'd0);
      chk("rst_data", 32'({data_out_1, data_out_2}), 32'h0);
      chk("rst_pix_ready", 32'(pix_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      HRESETn = 1'b1;
      step();

      // Three-pair frame, zero wait states
      begin_frame(32'h0000_1000, 16'd3);
      chk("f1_busy", 32'(busy), 32'd1);
      do_pair(32'h0000_1000, 8'h12, 8'h34, 1'b0);
      do_pair(32'h0000_1004, 8'h56, 8'h78, 1'b0);
      do_pair(32'h0000_1008, 8'h9A, 8'hBC, 1'b0);
      wait_done(10, 3);
      chk("f1_error", 32'(error), 32'd0);

      // Wait states: ADDR held 1 cycle, DATA held 2 cycles on the first pair
      begin_frame(32'h0000_2000, 16'd2);
      pix_valid = 1'b1;
      pix_a     = 8'hA1;
      pix_b     = 8'hB2;
      step();
      pix_valid = 1'b0;
      HREADY    = 1'b0;
      chk("ws_addr0_htrans", 32'(HTRANS), 32'h2);
      step();
      chk("ws_addr1_htrans", 32'(HTRANS), 32'h2);
      chk("ws_addr1_haddr", HADDR, 32'h0000_2000);
      chk("ws_addr1_shift", 32'(shift_enable), 32'd1);
      chk("ws_addr1_data", 32'({data_out_1, data_out_2}), 32'hA1B2);
      HREADY = 1'b1;
      step();
      chk("ws_data0_htrans", 32'(HTRANS), 32'h0);
      HREADY = 1'b0;
      step();
      chk("ws_data1_htrans", 32'(HTRANS), 32'h0);
      chk("ws_data1_haddr", HADDR, 32'h0000_2000);
      chk("ws_data1_data", 32'({data_out_1, data_out_2}), 32'hA1B2);
      step();
      chk("ws_data2_data", 32'({data_out_1, data_out_2}), 32'hA1B2);
      chk("ws_data2_pix_ready", 32'(pix_ready), 32'd0);
      HREADY = 1'b1;
      step();
      do_pair(32'h0000_2004, 8'hC3, 8'hD4, 1'b0);
      wait_done(10, 2);

      // Error response on pair 2 of 3
      begin_frame(32'h0000_4000, 16'd3);
      do_pair(32'h0000_4000, 8'h01, 8'h02, 1'b0);
      chk("err_before", 32'(error), 32'd0);
      do_pair(32'h0000_4004, 8'h03, 8'h04, 1'b1);
      chk("err_after_hs", 32'(error), 32'd1);
      do_pair(32'h0000_4008, 8'h05, 8'h06, 1'b0);
      wait_done(10, 3);
      chk("err_sticky", 32'(error), 32'd1);

      // Empty frame, also clears the sticky error
      begin_frame(32'h0000_3000, 16'd0);
      chk("empty_error_clr", 32'(error), 32'd0);
      chk("empty_htrans", 32'(HTRANS), 32'h0);
      chk("empty_pix_ready", 32'(pix_ready), 32'd0);
      wait_done(1, 0);

      // Backpressure then reset during a DATA wait
      begin_frame(32'h0000_5000, 16'd2);
      for (int i = 0; i < 4; i++) begin
         chk("bp_pix_ready", 32'(pix_ready), 32'd1);
         chk("bp_htrans", 32'(HTRANS), 32'h0);
         chk("bp_shift_en", 32'(shift_enable), 32'd0);
         step();
      end
      chk("bp_xfers", 32'(n_xfer - xfer_base), 32'd0);
      pix_valid = 1'b1;
      pix_a     = 8'h11;
      pix_b     = 8'h22;
      step();
      pix_valid = 1'b0;
      chk("mr_addr_haddr", HADDR, 32'h0000_5000);
      step();
      HREADY = 1'b0;
      step();
      chk("mr_data_wait", 32'({data_out_1, data_out_2}), 32'h1122);
      HRESETn = 1'b0;
      #1;
      chk("mr_haddr", HADDR, 32'h0);
      chk("mr_htrans", 32'(HTRANS), 32'h0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_data", 32'({data_out_1, data_out_2}), 32'h0);
      chk("mr_pix_ready", 32'(pix_ready), 32'd0);
      chk("mr_frame_done", 32'(frame_done), 32'd0);
      step();
      chk("mr_hold_busy", 32'(busy), 32'd0);
      HRESETn = 1'b1;
      HREADY  = 1'b1;
      step();
      chk("mr_idle_frame_done", 32'(frame_done), 32'd0);
      begin_frame(32'h0000_6000, 16'd1);
      do_pair(32'h0000_6000, 8'h77, 8'h88, 1'b0);
      wait_done(4, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
